local_sum_gen: RTL and testbench
================================

// Module: local_sum_gen
// PURPOSE
//   Neighbour-oriented local-sum stage of the simplified CCSDS-123.0-B-2 predictor.
//   Takes one band of samples in raster order (x fastest) and keeps a one-row line buffer.
//   For each sample it emits the sample, its wide local sum sigma(x,y) and position flags.
//   Its outputs feed the two-cycle enable-qualified delay stage directly downstream.
// PARAMETERS
//   DATA_WIDTH  16  sample width D (unsigned)
//   NX          64  samples per row; must be >= 2
//   NY          64  rows per frame; must be >= 1
//   X_W  $clog2(NX)  column counter width (derived; do not override)
//   Y_W  $clog2(NY)  row counter width (derived; do not override)
// PORTS
//   clk      in   1             single clock, rising edge
//   rst      in   1             synchronous reset, active-high
//   en_i     in   1             sample valid; no backpressure
//   sof_i    in   1             start of frame, qualified by en_i; forces (x,y)=(0,0)
//   data_i   in   DATA_WIDTH    sample s(x,y)
//   en_o     out  1             output valid
//   data_o   out  DATA_WIDTH    s(x,y), aligned with sum_o
//   sum_o    out  DATA_WIDTH+2  local sum sigma(x,y)
//   first_o  out  1             x==0 && y==0; sigma is undefined there and forced to 0
//   last_o   out  1             x==NX-1 && y==NY-1
// BEHAVIOUR
//   - Reset (synchronous, rst=1 at posedge): x/y counters, both pipeline stages, en_o, data_o, sum_o,
//     first_o and last_o all go to 0. Line buffer contents are not reset; they are never read while y==0.
//   - Cycles with en_i=0 change no state except the valid pipeline; idle gaps of any length are legal.
//   - Counters advance on en_i=1. x wraps NX-1 -> 0 and increments y; y wraps NY-1 -> 0, so a new frame
//     begins. If sof_i=1 with en_i=1, that sample takes (0,0) regardless of the counters. sof_i with
//     en_i=0 is ignored.
//   - Line buffer: NX entries, sample width. The sample at (x,y) is written at address x. NE=s(x+1,y-1) is
//     read at address x+1 before that address is overwritten. N and NW come from registers shifted on each
//     accepted sample. W is the previous accepted sample.
//   - Latency is 2 cycles, fixed: en_i at cycle t gives en_o at t+2, matching the downstream delay stage.
//     Stage 1 registers s, W, N, NW, NE and the case select. Stage 2 computes and registers sum_o.
//   - Sum, computed in DATA_WIDTH+2 bits with no overflow possible (max 4*(2^D-1)):
//       y>0, 0<x<NX-1 : W + NW + N + NE
//       y==0, x>0     : 4*W
//       y>0, x==0     : 2*(N + NE)
//       y>0, x==NX-1  : W + NW + 2*N
//       x==0, y==0    : 0, with first_o=1
//   - Pipeline outputs hold their last value while en_o=0. Downstream samples them only when en_o=1.
//   - A sof_i mid-frame abandons the partial frame. Row y==0 of the new frame must not read the line
//     buffer (the 4*W rule guarantees this).
//   - Reset mid-frame discards in-flight samples: en_o=0 from the next cycle, and the next en_i sample is (0,0).
// STRUCTURE
//   - Shared package predictor_pkg: localparam case codes LS_INNER, LS_TOP, LS_LEFT, LS_RIGHT and
//     LS_FIRST (3-bit), plus function ls_width(D)=D+2.
//   - One sub-module: line_buf_ram
//       parameters DEPTH=NX, WIDTH=DATA_WIDTH
//       one write port and one combinational read port, different addresses in the same cycle
//       infers distributed RAM or flops
//   - Top holds the counters, neighbour registers, case decode and the two pipeline stages.
// TESTING
//   Setup: NX=4, NY=3, D=16, stimulus s(x,y)=10*y+x, en_i high continuously unless noted.
//   1. Reset, then stream one frame. Required:
//        (0,0): first_o=1, sum 0
//        (2,0): sum 4
//        (0,1): sum 2
//        (1,1): sum 13
//        (3,1): sum 20
//        (3,2): last_o=1
//   2. Same frame with en_i toggling 1/0 and random 0-5 cycle gaps. Required: identical sums/flags, each
//      en_o exactly 2 cycles after its en_i.
//   3. Assert sof_i at (2,1) of frame 1. Required: that sample reports first_o=1 and sum 0; the next
//      sample reports sum 4*s(prev).
//   4. All samples 0xFFFF at an interior (x,y). Required: sum_o=0x3FFFC, no truncation, all 18 bits checked.
//   5. rst pulsed for 1 cycle during row 1, with 2 samples in flight. Required: en_o=0 the next cycle and
//      outputs 0; the next sample is treated as (0,0).
//   6. Two back-to-back frames without sof_i. Required: frame 2 sums equal frame 1, and last_o fires
//      once per frame.

Source files
------------

// File: rtl/predictor_pkg.sv
// Shared definitions for the simplified CCSDS-123 predictor:
// local-sum case codes and the local-sum width helper.
package predictor_pkg;

    typedef logic [2:0] ls_case_t;

    localparam ls_case_t LS_INNER = 3'd0;
    localparam ls_case_t LS_TOP   = 3'd1;
    localparam ls_case_t LS_LEFT  = 3'd2;
    localparam ls_case_t LS_RIGHT = 3'd3;
    localparam ls_case_t LS_FIRST = 3'd4;

    // The sum of four D-bit samples needs two extra bits.
    function automatic int unsigned ls_width(input int unsigned d);
        return d + 2;
    endfunction

endpackage

// File: rtl/local_sum_gen_if.sv
// Sample stream into the local-sum stage and the aligned sample/sum/flag stream out of it.
interface local_sum_gen_if
    import predictor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) ();

    localparam int unsigned SUM_W = ls_width(DATA_WIDTH);

    logic                  en_i;
    logic                  sof_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  en_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [SUM_W-1:0]      sum_o;
    logic                  first_o;
    logic                  last_o;

    modport master (
        output en_i, sof_i, data_i,
        input  en_o, data_o, sum_o, first_o, last_o
    );

    modport slave (
        input  en_i, sof_i, data_i,
        output en_o, data_o, sum_o, first_o, last_o
    );

endinterface

// File: rtl/line_buf_ram.sv
// One-row line buffer: single write port, combinational read port at a different address.
module line_buf_ram #(
    parameter  int unsigned DEPTH = 64,
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/local_sum_gen.sv
// Local-sum stage: raster counters, one-row line buffer, neighbour registers
// and a fixed two-stage pipeline producing s(x,y), sigma(x,y) and position flags.
module local_sum_gen
    import predictor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NX         = 64,
    parameter int unsigned NY         = 64
) (
    input logic            clk,
    input logic            rst,
    local_sum_gen_if.slave bus
);

    localparam int unsigned X_W   = $clog2(NX);
    localparam int unsigned Y_W   = (NY > 1) ? $clog2(NY) : 1;
    localparam int unsigned SUM_W = ls_width(DATA_WIDTH);
    localparam logic [X_W-1:0] X_MAX = X_W'(NX - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(NY - 1);

    logic [X_W-1:0]        x_q, cur_x, rd_addr;
    logic [Y_W-1:0]        y_q, cur_y;
    logic [DATA_WIDTH-1:0] w_q, n_q, nw_q, ne_c;
    ls_case_t              sel_c;

    logic                  s1_en, s1_last;
    logic [DATA_WIDTH-1:0] s1_data, s1_w, s1_n, s1_nw, s1_ne;
    ls_case_t              s1_sel;
    logic [SUM_W-1:0]      sum_c;

    // Position of the incoming sample; sof overrides the counters.
    always_comb begin
        cur_x = x_q;
        cur_y = y_q;
        if (bus.sof_i) begin
            cur_x = '0;
            cur_y = '0;
        end
    end

    // At the row end the read wraps to address 0, which already holds s(0,y): N for the next row start.
    always_comb begin
        rd_addr = cur_x + X_W'(1);
        if (cur_x == X_MAX) begin
            rd_addr = '0;
        end
    end

    always_comb begin
        sel_c = LS_INNER;
        if (cur_x == '0 && cur_y == '0) begin
            sel_c = LS_FIRST;
        end else if (cur_y == '0) begin
            sel_c = LS_TOP;
        end else if (cur_x == '0) begin
            sel_c = LS_LEFT;
        end else if (cur_x == X_MAX) begin
            sel_c = LS_RIGHT;
        end
    end

    line_buf_ram #(
        .DEPTH (NX),
        .WIDTH (DATA_WIDTH)
    ) u_line_buf (
        .clk   (clk),
        .we    (bus.en_i && !rst),
        .waddr (cur_x),
        .wdata (bus.data_i),
        .raddr (rd_addr),
        .rdata (ne_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (bus.en_i) begin
            if (cur_x == X_MAX) begin
                x_q <= '0;
                y_q <= (cur_y == Y_MAX) ? '0 : cur_y + Y_W'(1);
            end else begin
                x_q <= cur_x + X_W'(1);
                y_q <= cur_y;
            end
        end
    end

    // NE read now becomes N for the next column; N slides into NW.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q  <= '0;
            n_q  <= '0;
            nw_q <= '0;
        end else if (bus.en_i) begin
            w_q  <= bus.data_i;
            n_q  <= ne_c;
            nw_q <= n_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_en   <= 1'b0;
            s1_data <= '0;
            s1_w    <= '0;
            s1_n    <= '0;
            s1_nw   <= '0;
            s1_ne   <= '0;
            s1_sel  <= LS_INNER;
            s1_last <= 1'b0;
        end else begin
            s1_en <= bus.en_i;
            if (bus.en_i) begin
                s1_data <= bus.data_i;
                s1_w    <= w_q;
                s1_n    <= n_q;
                s1_nw   <= nw_q;
                s1_ne   <= ne_c;
                s1_sel  <= sel_c;
                s1_last <= (cur_x == X_MAX) && (cur_y == Y_MAX);
            end
        end
    end

    always_comb begin
        sum_c = '0;
        case (s1_sel)
            LS_INNER: sum_c = SUM_W'(s1_w) + SUM_W'(s1_nw) + SUM_W'(s1_n) + SUM_W'(s1_ne);
            LS_TOP:   sum_c = SUM_W'(s1_w) << 2;
            LS_LEFT:  sum_c = (SUM_W'(s1_n) + SUM_W'(s1_ne)) << 1;
            LS_RIGHT: sum_c = SUM_W'(s1_w) + SUM_W'(s1_nw) + (SUM_W'(s1_n) << 1);
            default:  sum_c = '0;
        endcase
    end

    // Stage 2 holds its payload while no sample is flowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.en_o    <= 1'b0;
            bus.data_o  <= '0;
            bus.sum_o   <= '0;
            bus.first_o <= 1'b0;
            bus.last_o  <= 1'b0;
        end else begin
            bus.en_o <= s1_en;
            if (s1_en) begin
                bus.data_o  <= s1_data;
                bus.sum_o   <= sum_c;
                bus.first_o <= (s1_sel == LS_FIRST);
                bus.last_o  <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_local_sum_gen.sv
// Self-checking bench for local_sum_gen: image-based reference model, fixed vectors and corner sequences.
module tb_local_sum_gen;

    localparam int NX = 4;
    localparam int NY = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    local_sum_gen_if #(.DATA_WIDTH(DW)) bus ();

    local_sum_gen #(
        .DATA_WIDTH (DW),
        .NX         (NX),
        .NY         (NY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int due;
        int data;
        int sum;
        bit first;
        bit last;
    } exp_t;

    typedef struct {
        int x;
        int y;
        int sum;
        bit first;
        bit last;
    } vec_t;

    int   cyc = 0;
    int   nchecks = 0;
    int   nerr = 0;
    exp_t expq[$];
    exp_t mon_e;
    int   img[NY][NX];
    int   mx = 0;
    int   my = 0;
    int   obs_sum[$];
    int   obs_data[$];
    bit   obs_first[$];
    bit   obs_last[$];
    vec_t tbl[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: place the sample in a frame image and apply the sigma rules directly.
    function automatic void model_accept(input int d, input bit sof, input int due);
        exp_t e;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        img[my][mx] = d;
        e.due   = due;
        e.data  = d;
        e.first = (mx == 0 && my == 0);
        e.last  = (mx == NX - 1 && my == NY - 1);
        if (mx == 0 && my == 0)
            e.sum = 0;
        else if (my == 0)
            e.sum = 4 * img[0][mx-1];
        else if (mx == 0)
            e.sum = 2 * (img[my-1][0] + img[my-1][1]);
        else if (mx == NX - 1)
            e.sum = img[my][mx-1] + img[my-1][mx-1] + 2 * img[my-1][mx];
        else
            e.sum = img[my][mx-1] + img[my-1][mx-1] + img[my-1][mx] + img[my-1][mx+1];
        expq.push_back(e);
        mx++;
        if (mx == NX) begin
            mx = 0;
            my++;
            if (my == NY) my = 0;
        end
    endfunction

    // Output monitor: every en_o must match the oldest outstanding sample, on its due cycle.
    always begin
        @(posedge clk);
        #2;
        if (bus.en_o) begin
            obs_sum.push_back(int'(bus.sum_o));
            obs_data.push_back(int'(bus.data_o));
            obs_first.push_back(bus.first_o);
            obs_last.push_back(bus.last_o);
            if (expq.size() == 0) begin
                nchecks++;
                nerr++;
                $display("FAIL unexpected en_o at cycle %0d: got 1, expected 0", cyc);
            end else begin
                mon_e = expq.pop_front();
                chk("en_o latency (cycle)", longint'(cyc), longint'(mon_e.due));
                chk("data_o", longint'(bus.data_o), longint'(mon_e.data));
                chk("sum_o", longint'(bus.sum_o), longint'(mon_e.sum));
                chk("first_o", longint'(bus.first_o), longint'(mon_e.first));
                chk("last_o", longint'(bus.last_o), longint'(mon_e.last));
            end
        end else if (expq.size() > 0 && expq[0].due == cyc) begin
            nchecks++;
            nerr++;
            $display("FAIL missing en_o at cycle %0d: got 0, expected 1", cyc);
            void'(expq.pop_front());
        end
    end

    task automatic drive(input bit en, input bit sof, input int d);
        @(negedge clk);
        bus.en_i   = en;
        bus.sof_i  = sof;
        bus.data_i = 16'(d);
        if (en) model_accept(d, sof, cyc + 2);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        bus.en_i  = 1'b0;
        bus.sof_i = 1'b0;
        n = 0;
        while (expq.size() > 0 && n < 20) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (expq.size() > 0) begin
            nchecks++;
            nerr++;
            $display("FAIL drain timeout: got %0d pending, expected 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        bus.en_i  = 1'b0;
        bus.sof_i = 1'b0;
        expq.delete();
        mx = 0;
        my = 0;
        @(posedge clk);
        #1;
        chk("reset en_o", longint'(bus.en_o), 0);
        chk("reset data_o", longint'(bus.data_o), 0);
        chk("reset sum_o", longint'(bus.sum_o), 0);
        chk("reset first_o", longint'(bus.first_o), 0);
        chk("reset last_o", longint'(bus.last_o), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_obs();
        obs_sum.delete();
        obs_data.delete();
        obs_first.delete();
        obs_last.delete();
    endtask

    task automatic apply_table(input string tag);
        int idx;
        for (int i = 0; i < 6; i++) begin
            idx = tbl[i].y * NX + tbl[i].x;
            if (idx < obs_sum.size()) begin
                chk($sformatf("%s sum(%0d,%0d)", tag, tbl[i].x, tbl[i].y), longint'(obs_sum[idx]), longint'(tbl[i].sum));
                chk($sformatf("%s first(%0d,%0d)", tag, tbl[i].x, tbl[i].y), longint'(obs_first[idx]), longint'(tbl[i].first));
                chk($sformatf("%s last(%0d,%0d)", tag, tbl[i].x, tbl[i].y), longint'(obs_last[idx]), longint'(tbl[i].last));
            end else begin
                nchecks++;
                nerr++;
                $display("FAIL %s output count: got %0d, expected > %0d", tag, obs_sum.size(), idx);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int gap;
        int lasts;
        bus.en_i   = 1'b0;
        bus.sof_i  = 1'b0;
        bus.data_i = '0;

        // s(x,y) = 10*y + x, NX=4, NY=3
        tbl[0] = '{x: 0, y: 0, sum: 0,  first: 1'b1, last: 1'b0};
        tbl[1] = '{x: 2, y: 0, sum: 4,  first: 1'b0, last: 1'b0};
        tbl[2] = '{x: 0, y: 1, sum: 2,  first: 1'b0, last: 1'b0};
        tbl[3] = '{x: 1, y: 1, sum: 13, first: 1'b0, last: 1'b0};
        tbl[4] = '{x: 3, y: 1, sum: 20, first: 1'b0, last: 1'b0};
        tbl[5] = '{x: 3, y: 2, sum: 60, first: 1'b0, last: 1'b1};

        // 1: reset, then one continuous frame
        do_reset();
        clear_obs();
        for (int i = 0; i < NX * NY; i++) drive(1'b1, 1'b0, 10 * (i / NX) + i % NX);
        drain();
        apply_table("continuous");

        // 2: same frame with idle gaps
        do_reset();
        clear_obs();
        for (int i = 0; i < NX * NY; i++) begin
            drive(1'b1, 1'b0, 10 * (i / NX) + i % NX);
            gap = (i % 2 == 0) ? 1 : int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 0);
        end
        drain();
        apply_table("gapped");

        // 3: sof at (2,1) restarts the frame
        do_reset();
        clear_obs();
        for (int i = 0; i < NX * NY; i++) drive(1'b1, (i == 6), 10 * (i / NX) + i % NX);
        drain();
        if (obs_sum.size() > 7) begin
            chk("sof first_o", longint'(obs_first[6]), 1);
            chk("sof sum_o", longint'(obs_sum[6]), 0);
            chk("after-sof sum_o", longint'(obs_sum[7]), 48);
        end else begin
            nchecks++;
            nerr++;
            $display("FAIL sof output count: got %0d, expected 12", obs_sum.size());
        end

        // 4: full-scale samples, interior sum needs all 18 bits
        do_reset();
        clear_obs();
        for (int i = 0; i < NX * NY; i++) drive(1'b1, 1'b0, 16'hFFFF);
        drain();
        if (obs_sum.size() > 5) begin
            chk("fullscale sum(1,1)", longint'(obs_sum[5]), longint'(18'h3FFFC));
            chk("fullscale data(1,1)", longint'(obs_data[5]), longint'(16'hFFFF));
        end else begin
            nchecks++;
            nerr++;
            $display("FAIL fullscale output count: got %0d, expected 12", obs_sum.size());
        end

        // 5: reset during row 1 with samples in flight
        do_reset();
        for (int i = 0; i < NX + 2; i++) drive(1'b1, 1'b0, 10 * (i / NX) + i % NX);
        do_reset();
        clear_obs();
        drive(1'b1, 1'b0, 99);
        drive(1'b1, 1'b0, 7);
        drain();
        if (obs_sum.size() == 2) begin
            chk("post-reset first_o", longint'(obs_first[0]), 1);
            chk("post-reset sum_o", longint'(obs_sum[0]), 0);
            chk("post-reset next sum_o", longint'(obs_sum[1]), 396);
        end else begin
            nchecks++;
            nerr++;
            $display("FAIL post-reset output count: got %0d, expected 2", obs_sum.size());
        end

        // 6: two back-to-back frames without sof
        do_reset();
        clear_obs();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < NX * NY; i++) drive(1'b1, 1'b0, 10 * (i / NX) + i % NX);
        drain();
        if (obs_sum.size() == 2 * NX * NY) begin
            for (int i = 0; i < NX * NY; i++)
                chk($sformatf("frame2 sum[%0d]", i), longint'(obs_sum[i + NX * NY]), longint'(obs_sum[i]));
            lasts = 0;
            foreach (obs_last[i]) lasts += int'(obs_last[i]);
            chk("last_o count over 2 frames", longint'(lasts), 2);
            chk("frame1 last_o at end", longint'(obs_last[NX * NY - 1]), 1);
        end else begin
            nchecks++;
            nerr++;
            $display("FAIL two-frame output count: got %0d, expected %0d", obs_sum.size(), 2 * NX * NY);
        end

        // Random traffic with occasional sof, checked by the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1)
                drive(1'b1, ($urandom_range(0, 15) == 0), int'($urandom_range(0, 65535)));
            else
                drive(1'b0, 1'b0, 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
